// File: rtl/amba3_axi_rom_slave.sv
// AXI3 read-only slave backed by a word-addressed memory that is preloaded
// through a backdoor port. It serves one burst at a time and supports the
// FIXED, INCR and WRAP burst types with a registered one-beat data path.
//
// Handshake rule (AR and R channels): a transfer happens on the rising aclk
// edge where valid and ready are both 1. While rvalid=1 and rready=0, the
// payload (rid, rdata, rresp, rlast) is held unchanged.
module amba3_axi_rom_slave #(
  parameter int TXID_BITS = 4,
  parameter int ADDR_BITS = 32,
  parameter int DATA_BITS = 32,
  parameter int MEM_WORDS = 1024
) (
  input  logic                         aclk,
  input  logic                         areset_n,
  input  logic [TXID_BITS-1:0]         arid,
  input  logic [ADDR_BITS-1:0]         araddr,
  input  logic [3:0]                   arlen,
  input  logic [2:0]                   arsize,
  input  logic [1:0]                   arburst,
  input  logic                         arvalid,
  output logic                         arready,
  output logic [TXID_BITS-1:0]         rid,
  output logic [DATA_BITS-1:0]         rdata,
  output logic [1:0]                   rresp,
  output logic                         rlast,
  output logic                         rvalid,
  input  logic                         rready,
  input  logic                         ld_en,
  input  logic [$clog2(MEM_WORDS)-1:0] ld_addr,
  input  logic [DATA_BITS-1:0]         ld_data,
  output logic                         dbg_state
);

  localparam int              LSB      = $clog2(DATA_BITS / 8);
  localparam logic [2:0]      MAX_SIZE = 3'(LSB);
  localparam int              MW_BITS  = $clog2(MEM_WORDS);
  localparam logic [1:0]      RESP_OK  = 2'd0;
  localparam logic [1:0]      RESP_ERR = 2'd2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DATA = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Goes high on the first edge after reset release so arready stays low in reset.
  logic r_alive;

  // Burst context captured at the AR handshake.
  logic [TXID_BITS-1:0] r_id;
  logic [3:0]           r_len;
  logic [2:0]           r_size;
  logic [1:0]           r_burst;
  logic                 r_err;
  logic [ADDR_BITS-1:0] r_wrap_mask;

  // Current beat.
  logic [ADDR_BITS-1:0] r_addr;
  logic [3:0]           r_beat;
  logic [DATA_BITS-1:0] r_rdata;
  logic [1:0]           r_rresp;
  logic                 r_rlast;

  logic [DATA_BITS-1:0] r_mem [MEM_WORDS];

  logic                 w_arready;
  logic                 w_rvalid;
  logic                 w_ar_hs;
  logic                 w_r_adv;
  logic                 w_load_en;
  logic [ADDR_BITS-1:0] w_sz;
  logic [ADDR_BITS-1:0] w_aligned;
  logic [ADDR_BITS-1:0] w_inc;
  logic [ADDR_BITS-1:0] w_next_addr;
  logic                 w_ar_err;
  logic [ADDR_BITS-1:0] w_ar_mask;
  logic [ADDR_BITS-1:0] w_load_addr;
  logic                 w_load_err;
  logic [3:0]           w_load_beat;
  logic                 w_load_last;
  logic [ADDR_BITS-1:0] w_idx;
  logic                 w_oob;
  logic [DATA_BITS-1:0] w_mem_rd;

  // FSM state register.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) r_state <= ST_IDLE;
    else           r_state <= w_state_nxt;
  end

  // Post-reset enable for the address channel.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) r_alive <= 1'b0;
    else           r_alive <= 1'b1;
  end

  // FSM next state, channel handshakes and beat-advance strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_arready   = 1'b0;
    w_rvalid    = 1'b0;
    w_ar_hs     = 1'b0;
    w_r_adv     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_arready = r_alive;
        if (arvalid && r_alive) begin
          w_ar_hs     = 1'b1;
          w_state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        w_rvalid = 1'b1;
        if (rready) begin
          if (r_rlast) w_state_nxt = ST_IDLE;
          else         w_r_adv     = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Address generation for the next beat and selection of the beat to load.
  always_comb begin
    w_sz      = ADDR_BITS'(1) << r_size;
    w_aligned = r_addr & ~(w_sz - ADDR_BITS'(1));
    w_inc     = w_aligned + w_sz;
    case (r_burst)
      2'd0:    w_next_addr = r_addr;
      // The wrap region is a power of two; keep the region bits, wrap the offset.
      2'd2:    w_next_addr = (r_addr & ~r_wrap_mask) | (w_inc & r_wrap_mask);
      default: w_next_addr = w_inc;
    endcase

    w_ar_err  = (arsize > MAX_SIZE) || (arburst == 2'd3) ||
                ((arburst == 2'd2) && !(arlen inside {4'd1, 4'd3, 4'd7, 4'd15}));
    w_ar_mask = ((ADDR_BITS'(arlen) + ADDR_BITS'(1)) << arsize) - ADDR_BITS'(1);

    w_load_en   = w_ar_hs || w_r_adv;
    w_load_addr = w_ar_hs ? araddr : w_next_addr;
    w_load_err  = w_ar_hs ? w_ar_err : r_err;
    w_load_beat = w_ar_hs ? 4'd0 : (r_beat + 4'd1);
    w_load_last = w_ar_hs ? (arlen == 4'd0) : (w_load_beat == r_len);

    w_idx    = w_load_addr >> LSB;
    w_oob    = (w_idx >= ADDR_BITS'(MEM_WORDS));
    w_mem_rd = r_mem[w_idx[MW_BITS-1:0]];
  end

  // Burst context capture and registered beat payload.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      r_id        <= '0;
      r_len       <= '0;
      r_size      <= '0;
      r_burst     <= '0;
      r_err       <= 1'b0;
      r_wrap_mask <= '0;
      r_addr      <= '0;
      r_beat      <= '0;
      r_rdata     <= '0;
      r_rresp     <= RESP_OK;
      r_rlast     <= 1'b0;
    end else begin
      if (w_ar_hs) begin
        r_id        <= arid;
        r_len       <= arlen;
        r_size      <= arsize;
        r_burst     <= arburst;
        r_err       <= w_ar_err;
        r_wrap_mask <= w_ar_mask;
      end
      if (w_load_en) begin
        r_addr  <= w_load_addr;
        r_beat  <= w_load_beat;
        r_rlast <= w_load_last;
        if (w_load_err || w_oob) begin
          r_rdata <= '0;
          r_rresp <= RESP_ERR;
        end else begin
          r_rdata <= w_mem_rd;
          r_rresp <= RESP_OK;
        end
      end
    end
  end

  // Backdoor preload; not reset so contents survive areset_n.
  always_ff @(posedge aclk) begin
    if (ld_en) r_mem[ld_addr] <= ld_data;
  end

  assign arready   = w_arready;
  assign rvalid    = w_rvalid;
  assign rid       = r_id;
  assign rdata     = r_rdata;
  assign rresp     = r_rresp;
  assign rlast     = r_rlast;
  assign dbg_state = r_state;

endmodule
